// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - five-band gain mixer with a single shared multiplier
// Snapshots band outputs a fixed latency after the sample strobe and emits a rounded, saturated sum.
module eq_band_mixer #(
    parameter int N_BAND    = 5,
    parameter int BAND_LAT  = 10,
    parameter int GAIN_FRAC = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_data,
    input  logic [N_BAND*16-1:0]   band_y,
    input  logic [N_BAND*8-1:0]    gain,
    output logic [15:0]            y_out,
    output logic                   y_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int CW = $clog2(BAND_LAT + 1);
    localparam int IW = $clog2(N_BAND);
    localparam logic signed [27:0] RND_HALF = 28'sd1 <<< (GAIN_FRAC - 1);
    localparam logic signed [27:0] SAT_MAX  = 28'sd32767;
    localparam logic signed [27:0] SAT_MIN  = -28'sd32768;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_MAC,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      wait_cnt;
    logic [IW-1:0]      idx;
    logic signed [15:0] band_q [N_BAND];
    logic [7:0]         gain_q [N_BAND];
    logic signed [27:0] acc;
    logic signed [24:0] prod;
    logic signed [27:0] acc_rnd;
    logic signed [27:0] acc_shf;
    logic [15:0]        y_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (new_data) state_nxt = S_WAIT;
            S_WAIT: if (wait_cnt == '0) state_nxt = S_MAC;
            S_MAC:  if (idx == IW'(N_BAND - 1)) state_nxt = S_OUT;
            S_OUT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Gain is zero-extended to 9 bits so the product stays a plain signed multiply.
    assign prod    = 25'(band_q[idx]) * 25'($signed({1'b0, gain_q[idx]}));
    assign acc_rnd = acc + RND_HALF;
    assign acc_shf = acc_rnd >>> GAIN_FRAC;

    always_comb begin
        y_sat = acc_shf[15:0];
        if (acc_shf > SAT_MAX) begin
            y_sat = 16'h7fff;
        end else if (acc_shf < SAT_MIN) begin
            y_sat = 16'h8000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            idx      <= '0;
            acc      <= '0;
            y_out    <= '0;
            y_valid  <= 1'b0;
            overrun  <= 1'b0;
            for (int k = 0; k < N_BAND; k++) begin
                band_q[k] <= '0;
                gain_q[k] <= '0;
            end
        end else begin
            y_valid <= 1'b0;
            overrun <= new_data && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (new_data) begin
                        wait_cnt <= CW'(BAND_LAT - 1);
                        for (int k = 0; k < N_BAND; k++) begin
                            gain_q[k] <= gain[8*k +: 8];
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        acc <= '0;
                        idx <= '0;
                        for (int k = 0; k < N_BAND; k++) begin
                            band_q[k] <= band_y[16*k +: 16];
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_MAC: begin
                    acc <= acc + 28'(prod);
                    idx <= idx + IW'(1);
                end
                S_OUT: begin
                    y_out   <= y_sat;
                    y_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - randomized self-checking bench for eq_band_mixer
// Results are compared against an integer reference of the weighted band sum.
module tb_eq_band_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_data = 1'b0;
    logic [79:0] band_y = '0;
    logic [39:0] gain = '0;
    logic [15:0] y_out;
    logic        y_valid;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_fail = 0;

    eq_band_mixer dut (
        .clk      (clk),
        .rst      (rst),
        .new_data (new_data),
        .band_y   (band_y),
        .gain     (gain),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [79:0] b, input logic [39:0] g);
        longint acc = 0;
        longint q;
        longint r;
        for (int k = 0; k < 5; k++) begin
            logic signed [15:0] bs;
            logic [7:0]         gs;
            bs = b[16*k +: 16];
            gs = g[8*k +: 8];
            acc += longint'(bs) * longint'(gs);
        end
        q = acc + 32;
        r = (q >= 0) ? q / 64 : -((-q + 63) / 64);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    function automatic logic [79:0] all_bands(input logic [15:0] v);
        return {v, v, v, v, v};
    endfunction

    function automatic logic [39:0] all_gains(input logic [7:0] v);
        return {v, v, v, v, v};
    endfunction

    task automatic run_sample(input logic [79:0] b, input logic [39:0] g,
                              output logic [15:0] y, output int lat,
                              output int bcnt, output int vcnt);
        band_y = b;
        gain = g;
        new_data = 1'b1;
        @(posedge clk); #1;
        new_data = 1'b0;
        lat = -1; bcnt = 0; vcnt = 0; y = '0;
        for (int k = 1; k <= 24; k++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            if (y_valid) begin
                vcnt++;
                if (lat < 0) begin
                    lat = k;
                    y = y_out;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (y_out !== 16'd0) begin n_fail++; $display("FAIL reset_y_out: got %0h want 0", y_out); end
        n_cmp++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b want 0", y_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unity;
        logic [15:0] y;
        int lat, bcnt, vcnt;
        run_sample(all_bands(16'd1000), all_gains(8'd64), y, lat, bcnt, vcnt);
        n_cmp++; if (y !== 16'd5000) begin n_fail++; $display("FAIL unity_value: got %0d want 5000", $signed(y)); end
        n_cmp++; if (lat !== 16) begin n_fail++; $display("FAIL unity_latency: got %0d want 16", lat); end
        n_cmp++; if (bcnt !== 16) begin n_fail++; $display("FAIL unity_busy_cycles: got %0d want 16", bcnt); end
        n_cmp++; if (vcnt !== 1) begin n_fail++; $display("FAIL unity_valid_count: got %0d want 1", vcnt); end
    endtask

    task automatic test_saturation;
        logic [15:0] y;
        int lat, bcnt, vcnt;
        run_sample(all_bands(16'h7fff), all_gains(8'd255), y, lat, bcnt, vcnt);
        n_cmp++; if (y !== 16'h7fff) begin n_fail++; $display("FAIL sat_pos: got %0d want 32767", $signed(y)); end
        run_sample(all_bands(16'h8000), all_gains(8'd255), y, lat, bcnt, vcnt);
        n_cmp++; if (y !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %0d want -32768", $signed(y)); end
    endtask

    task automatic test_rounding;
        logic [15:0] y;
        logic [15:0] vals [3];
        logic [15:0] want [3];
        int lat, bcnt, vcnt;
        vals[0] = 16'd1;      want[0] = 16'd1;
        vals[1] = 16'hffff;   want[1] = 16'd0;
        vals[2] = 16'hfffd;   want[2] = 16'hffff;
        for (int i = 0; i < 3; i++) begin
            run_sample({64'd0, vals[i]}, {32'd0, 8'd32}, y, lat, bcnt, vcnt);
            n_cmp++;
            if (y !== want[i] || y !== model({64'd0, vals[i]}, {32'd0, 8'd32})) begin
                n_fail++;
                $display("FAIL rounding_%0d: got %0d want %0d", i, $signed(y), $signed(want[i]));
            end
        end
    endtask

    task automatic test_isolation;
        logic [79:0] b0;
        logic [39:0] g0;
        logic [15:0] y;
        int lat;
        b0 = 80'({$urandom, $urandom, $urandom});
        g0 = 40'({$urandom, $urandom});
        band_y = b0; gain = g0; new_data = 1'b1;
        @(posedge clk); #1;
        new_data = 1'b0;
        lat = -1; y = '0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (k == 1) gain = ~g0;
            if (k == 11) band_y = ~b0;
            if (y_valid && lat < 0) begin lat = k; y = y_out; end
        end
        n_cmp++; if (y !== model(b0, g0)) begin n_fail++; $display("FAIL isolation_value: got %0d want %0d", $signed(y), $signed(model(b0, g0))); end
        n_cmp++; if (lat !== 16) begin n_fail++; $display("FAIL isolation_latency: got %0d want 16", lat); end
    endtask

    task automatic test_overrun;
        logic [79:0] b1, b2;
        logic [39:0] g1, g2;
        logic [15:0] y1, y2;
        int v_edge [$];
        int o_edge [$];
        b1 = 80'({$urandom, $urandom, $urandom});
        g1 = 40'({$urandom, $urandom});
        b2 = 80'({$urandom, $urandom, $urandom});
        g2 = 40'({$urandom, $urandom});
        band_y = b1; gain = g1;
        y1 = '0; y2 = '0;
        for (int k = 0; k <= 40; k++) begin
            new_data = (k == 0 || k == 5 || k == 17);
            @(posedge clk); #1;
            if (k == 16) begin band_y = b2; gain = g2; end
            if (y_valid) begin
                if (v_edge.size() == 0) y1 = y_out; else y2 = y_out;
                v_edge.push_back(k);
            end
            if (overrun) o_edge.push_back(k);
        end
        new_data = 1'b0;
        n_cmp++; if (o_edge.size() !== 1) begin n_fail++; $display("FAIL overrun_count: got %0d want 1", o_edge.size()); end
        else begin
            n_cmp++; if (o_edge[0] !== 5) begin n_fail++; $display("FAIL overrun_edge: got %0d want 5", o_edge[0]); end
        end
        n_cmp++; if (v_edge.size() !== 2) begin n_fail++; $display("FAIL overrun_valid_count: got %0d want 2", v_edge.size()); end
        else begin
            n_cmp++; if (v_edge[0] !== 16 || v_edge[1] !== 33) begin n_fail++; $display("FAIL overrun_valid_edges: got %0d,%0d want 16,33", v_edge[0], v_edge[1]); end
        end
        n_cmp++; if (y1 !== model(b1, g1)) begin n_fail++; $display("FAIL overrun_first_value: got %0d want %0d", $signed(y1), $signed(model(b1, g1))); end
        n_cmp++; if (y2 !== model(b2, g2)) begin n_fail++; $display("FAIL overrun_second_value: got %0d want %0d", $signed(y2), $signed(model(b2, g2))); end
    endtask

    task automatic test_reset_mid;
        logic [79:0] b;
        logic [39:0] g;
        logic [15:0] y;
        int lat, bcnt, vcnt, vseen;
        run_sample(all_bands(16'd1234), all_gains(8'd64), y, lat, bcnt, vcnt);
        b = 80'({$urandom, $urandom, $urandom});
        g = 40'({$urandom, $urandom});
        band_y = b; gain = g; new_data = 1'b1;
        @(posedge clk); #1;
        new_data = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (y_out !== 16'd0) begin n_fail++; $display("FAIL midreset_y_out: got %0h want 0", y_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        vseen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (y_valid) vseen++;
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (y_valid) vseen++;
        end
        n_cmp++; if (vseen !== 0) begin n_fail++; $display("FAIL midreset_no_valid: got %0d pulses want 0", vseen); end
        run_sample(b, g, y, lat, bcnt, vcnt);
        n_cmp++; if (y !== model(b, g)) begin n_fail++; $display("FAIL midreset_after_value: got %0d want %0d", $signed(y), $signed(model(b, g))); end
        n_cmp++; if (lat !== 16) begin n_fail++; $display("FAIL midreset_after_latency: got %0d want 16", lat); end
    endtask

    task automatic test_random;
        logic [79:0] b;
        logic [39:0] g;
        logic [15:0] y;
        int lat, bcnt, vcnt;
        for (int i = 0; i < 25; i++) begin
            b = 80'({$urandom, $urandom, $urandom});
            g = 40'({$urandom, $urandom});
            if (i % 3 == 0) g = {g[39:8] & 32'h3f3f3f3f, g[7:0] & 8'h3f};
            run_sample(b, g, y, lat, bcnt, vcnt);
            n_cmp++;
            if (y !== model(b, g) || lat !== 16 || vcnt !== 1) begin
                n_fail++;
                $display("FAIL random_%0d: got %0d lat %0d valids %0d want %0d lat 16 valids 1",
                         i, $signed(y), lat, vcnt, $signed(model(b, g)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_saturation();
        test_rounding();
        test_isolation();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
